// File: rtl/timer_sequencer.sv
// Step-sequence controller for a downstream timer. It holds a table of timer
// configurations and advances through it by counting top_match periods.
module timer_sequencer #(
  parameter int PRESCALER_BITS = 8,
  parameter int TIMER_BITS     = 16,
  parameter int STEPS          = 8,
  parameter int REPEAT_BITS    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(STEPS)-1:0]    wr_addr,
  input  logic [PRESCALER_BITS-1:0]   wr_prescaler,
  input  logic [TIMER_BITS-1:0]       wr_top,
  input  logic [TIMER_BITS-1:0]       wr_cmp,
  input  logic [REPEAT_BITS-1:0]      wr_repeat,
  input  logic [$clog2(STEPS):0]      num_steps,
  input  logic                        loop,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        tmr_top_match,
  output logic [PRESCALER_BITS-1:0]   tmr_prescaler_cnt,
  output logic [TIMER_BITS-1:0]       tmr_top_cnt,
  output logic [TIMER_BITS-1:0]       tmr_cmp_cnt,
  output logic                        tmr_go,
  output logic                        tmr_relatch,
  output logic                        busy,
  output logic [$clog2(STEPS)-1:0]    step_idx,
  output logic                        step_done,
  output logic                        seq_done
);

  localparam int IDX_BITS = $clog2(STEPS);
  localparam int NUM_BITS = IDX_BITS + 1;
  localparam logic [NUM_BITS-1:0] STEPS_N = NUM_BITS'(STEPS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] RELATCH = 2'd2;

  logic [PRESCALER_BITS-1:0] presc_tab_q [STEPS];
  logic [TIMER_BITS-1:0]     top_tab_q   [STEPS];
  logic [TIMER_BITS-1:0]     cmp_tab_q   [STEPS];
  logic [REPEAT_BITS-1:0]    rep_tab_q   [STEPS];

  logic [1:0]                state_q, state_d;
  logic [IDX_BITS-1:0]       idx_q, idx_d;
  logic [REPEAT_BITS-1:0]    rep_q, rep_d;
  logic [NUM_BITS-1:0]       num_q, num_d;
  logic                      loop_q, loop_d;
  logic [PRESCALER_BITS-1:0] presc_q, presc_d;
  logic [TIMER_BITS-1:0]     top_q, top_d;
  logic [TIMER_BITS-1:0]     cmp_q, cmp_d;
  logic                      go_q, go_d;
  logic                      relatch_q, relatch_d;
  logic                      busy_q, busy_d;
  logic                      step_done_q, step_done_d;
  logic                      seq_done_q, seq_done_d;

  logic                      load;
  logic [IDX_BITS-1:0]       load_idx;

  // NOTE: the table is reset explicitly, so it maps to flops rather than a RAM
  // macro; a restart after reset must see all-zero entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        presc_tab_q[i] <= '0;
        top_tab_q[i]   <= '0;
        cmp_tab_q[i]   <= '0;
        rep_tab_q[i]   <= '0;
      end
    end else if (wr_en) begin
      presc_tab_q[wr_addr] <= wr_prescaler;
      top_tab_q[wr_addr]   <= wr_top;
      cmp_tab_q[wr_addr]   <= wr_cmp;
      rep_tab_q[wr_addr]   <= wr_repeat;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    num_d       = num_q;
    loop_d      = loop_q;
    presc_d     = presc_q;
    top_d       = top_q;
    cmp_d       = cmp_q;
    go_d        = go_q;
    relatch_d   = 1'b0;
    busy_d      = busy_q;
    step_done_d = 1'b0;
    seq_done_d  = 1'b0;
    load        = 1'b0;
    load_idx    = idx_q;

    case (state_q)
      IDLE: begin
        if (start && !stop && (num_steps != '0)) begin
          state_d  = RUN;
          num_d    = (num_steps > STEPS_N) ? STEPS_N : num_steps;
          loop_d   = loop;
          idx_d    = '0;
          rep_d    = '0;
          load     = 1'b1;
          load_idx = '0;
          go_d     = 1'b1;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          go_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (tmr_top_match) begin
          if (rep_q != rep_tab_q[idx_q]) begin
            rep_d = rep_q + REPEAT_BITS'(1);
          end else if (({1'b0, idx_q} < (num_q - NUM_BITS'(1))) || loop_q) begin
            // Advance or wrap; both pulse relatch so table edits take effect.
            idx_d       = ({1'b0, idx_q} < (num_q - NUM_BITS'(1)))
                          ? idx_q + IDX_BITS'(1) : '0;
            load        = 1'b1;
            load_idx    = idx_d;
            rep_d       = '0;
            relatch_d   = 1'b1;
            step_done_d = 1'b1;
            state_d     = RELATCH;
          end else begin
            step_done_d = 1'b1;
            seq_done_d  = 1'b1;
            go_d        = 1'b0;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      RELATCH: begin
        if (stop) begin
          state_d = IDLE;
          go_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      presc_d = presc_tab_q[load_idx];
      top_d   = top_tab_q[load_idx];
      cmp_d   = cmp_tab_q[load_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rep_q       <= '0;
      num_q       <= '0;
      loop_q      <= 1'b0;
      presc_q     <= '0;
      top_q       <= '0;
      cmp_q       <= '0;
      go_q        <= 1'b0;
      relatch_q   <= 1'b0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      num_q       <= num_d;
      loop_q      <= loop_d;
      presc_q     <= presc_d;
      top_q       <= top_d;
      cmp_q       <= cmp_d;
      go_q        <= go_d;
      relatch_q   <= relatch_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign tmr_prescaler_cnt = presc_q;
  assign tmr_top_cnt       = top_q;
  assign tmr_cmp_cnt       = cmp_q;
  assign tmr_go            = go_q;
  assign tmr_relatch       = relatch_q;
  assign busy              = busy_q;
  assign step_idx          = idx_q;
  assign step_done         = step_done_q;
  assign seq_done          = seq_done_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed testbench for timer_sequencer; the bench itself drives top_match
// pulses in place of a timer and checks each reaction against fixed values.
module tb_timer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_prescaler = '0;
  logic [15:0] wr_top = '0;
  logic [15:0] wr_cmp = '0;
  logic [7:0]  wr_repeat = '0;
  logic [3:0]  num_steps = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tmr_top_match = 1'b0;
  logic [7:0]  tmr_prescaler_cnt;
  logic [15:0] tmr_top_cnt;
  logic [15:0] tmr_cmp_cnt;
  logic        tmr_go;
  logic        tmr_relatch;
  logic        busy;
  logic [2:0]  step_idx;
  logic        step_done;
  logic        seq_done;

  int checks = 0;
  int errors = 0;
  int relatch_cnt;
  int seq_done_cnt;

  timer_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_prescaler      (wr_prescaler),
    .wr_top            (wr_top),
    .wr_cmp            (wr_cmp),
    .wr_repeat         (wr_repeat),
    .num_steps         (num_steps),
    .loop              (loop),
    .start             (start),
    .stop              (stop),
    .tmr_top_match     (tmr_top_match),
    .tmr_prescaler_cnt (tmr_prescaler_cnt),
    .tmr_top_cnt       (tmr_top_cnt),
    .tmr_cmp_cnt       (tmr_cmp_cnt),
    .tmr_go            (tmr_go),
    .tmr_relatch       (tmr_relatch),
    .busy              (busy),
    .step_idx          (step_idx),
    .step_done         (step_done),
    .seq_done          (seq_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [7:0] p, input logic [15:0] t,
                             input logic [15:0] c, input logic [7:0] r);
    wr_en = 1'b1; wr_addr = a; wr_prescaler = p; wr_top = t; wr_cmp = c; wr_repeat = r;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_match();
    tmr_top_match = 1'b1;
    tick();
    tmr_top_match = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_presc"},   32'(tmr_prescaler_cnt), 0);
    check({tag, "_top"},     32'(tmr_top_cnt), 0);
    check({tag, "_cmp"},     32'(tmr_cmp_cnt), 0);
    check({tag, "_go"},      32'(tmr_go), 0);
    check({tag, "_relatch"}, 32'(tmr_relatch), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_idx"},     32'(step_idx), 0);
    check({tag, "_sdone"},   32'(step_done), 0);
    check({tag, "_qdone"},   32'(seq_done), 0);
  endtask

  initial begin
    // Reset state
    idle_ticks(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Two steps, no loop
    write_entry(3'd0, 8'd3, 16'd4, 16'd1, 8'd1);
    write_entry(3'd1, 8'd1, 16'd2, 16'd0, 8'd0);
    num_steps = 4'd2; loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", 32'(busy), 1);
    check("t1_go", 32'(tmr_go), 1);
    check("t1_idx", 32'(step_idx), 0);
    check("t1_presc", 32'(tmr_prescaler_cnt), 3);
    check("t1_top", 32'(tmr_top_cnt), 4);
    check("t1_cmp", 32'(tmr_cmp_cnt), 1);
    idle_ticks(11);
    pulse_match();
    check("t1_m1_sdone", 32'(step_done), 0);
    check("t1_m1_relatch", 32'(tmr_relatch), 0);
    check("t1_m1_idx", 32'(step_idx), 0);
    idle_ticks(11);
    pulse_match();
    check("t1_m2_sdone", 32'(step_done), 1);
    check("t1_m2_relatch", 32'(tmr_relatch), 1);
    check("t1_m2_idx", 32'(step_idx), 1);
    check("t1_m2_presc", 32'(tmr_prescaler_cnt), 1);
    check("t1_m2_top", 32'(tmr_top_cnt), 2);
    check("t1_m2_cmp", 32'(tmr_cmp_cnt), 0);
    check("t1_m2_qdone", 32'(seq_done), 0);
    tick();
    check("t1_rl_short", 32'(tmr_relatch), 0);
    check("t1_sdone_short", 32'(step_done), 0);
    tick();
    pulse_match();
    check("t1_end_qdone", 32'(seq_done), 1);
    check("t1_end_sdone", 32'(step_done), 1);
    check("t1_end_go", 32'(tmr_go), 0);
    check("t1_end_busy", 32'(busy), 0);
    check("t1_end_top_hold", 32'(tmr_top_cnt), 2);
    tick();
    check("t1_qdone_short", 32'(seq_done), 0);

    // Loop: 40 pulses, 5 clk apart; step0 takes 2, step1 takes 1
    loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    relatch_cnt = 0;
    seq_done_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      tmr_top_match = (c % 5 == 4);
      tick();
      if (tmr_relatch) relatch_cnt++;
      if (seq_done) seq_done_cnt++;
      if (c == 9) check("t2_idx_after_p2", 32'(step_idx), 1);
      if (c == 14) begin
        check("t2_wrap_idx", 32'(step_idx), 0);
        check("t2_wrap_relatch", 32'(tmr_relatch), 1);
        check("t2_wrap_presc", 32'(tmr_prescaler_cnt), 3);
      end
    end
    tmr_top_match = 1'b0;
    check("t2_relatch_cnt", 32'(relatch_cnt), 26);
    check("t2_seq_done_cnt", 32'(seq_done_cnt), 0);
    check("t2_busy", 32'(busy), 1);

    // Stop with a simultaneous step-changing top_match
    stop = 1'b1; tmr_top_match = 1'b1;
    tick();
    stop = 1'b0; tmr_top_match = 1'b0;
    check("t3_go", 32'(tmr_go), 0);
    check("t3_busy", 32'(busy), 0);
    check("t3_sdone", 32'(step_done), 0);
    check("t3_qdone", 32'(seq_done), 0);
    check("t3_relatch", 32'(tmr_relatch), 0);
    tick();
    check("t3_go_stays", 32'(tmr_go), 0);

    // Restart from step 0 and edit step1 top while running step 0
    loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_idx", 32'(step_idx), 0);
    check("t4_busy", 32'(busy), 1);
    pulse_match();
    check("t4_rep_reset", 32'(step_done), 0);
    write_entry(3'd1, 8'd1, 16'd6, 16'd0, 8'd0);
    pulse_match();
    check("t4_sdone", 32'(step_done), 1);
    check("t4_idx1", 32'(step_idx), 1);
    check("t4_edit_top", 32'(tmr_top_cnt), 6);
    tick();
    pulse_match();
    check("t4_qdone", 32'(seq_done), 1);

    // start with num_steps=0 is ignored
    num_steps = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_zero_busy", 32'(busy), 0);
    check("t5_zero_go", 32'(tmr_go), 0);
    tick();
    check("t5_zero_sdone", 32'(step_done), 0);

    // start+stop together in IDLE
    num_steps = 4'd2; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5_ss_busy", 32'(busy), 0);
    check("t5_ss_go", 32'(tmr_go), 0);

    // num_steps=15 clamps to 8
    for (int i = 2; i < 8; i++) write_entry(3'(i), 8'd2, 16'(10 + i), 16'd1, 8'd0);
    num_steps = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    pulse_match();
    for (int s = 0; s < 8; s++) begin
      pulse_match();
      if (s < 7) begin
        check("t6_idx", 32'(step_idx), 32'(s + 1));
        check("t6_top", 32'(tmr_top_cnt), (s == 0) ? 32'd6 : 32'(11 + s));
        check("t6_qdone_early", 32'(seq_done), 0);
        tick();
      end else begin
        check("t6_qdone", 32'(seq_done), 1);
        check("t6_busy", 32'(busy), 0);
        check("t6_last_idx", 32'(step_idx), 7);
      end
    end

    // Reset mid-run clears outputs and table
    num_steps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("t7_busy_pre", 32'(busy), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("t7_rst");
    num_steps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("t7_busy", 32'(busy), 1);
    check("t7_go", 32'(tmr_go), 1);
    check("t7_presc", 32'(tmr_prescaler_cnt), 0);
    check("t7_top", 32'(tmr_top_cnt), 0);
    check("t7_cmp", 32'(tmr_cmp_cnt), 0);
    pulse_match();
    check("t7_qdone", 32'(seq_done), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
